// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation operand sequencer: select codes,
// the 7-step select/carry schedule and the controller state encoding.
package interp_pkg;

    localparam int N_STEPS = 7;

    localparam logic [2:0] SEL_NEG_E2  = 3'b000;
    localparam logic [2:0] SEL_NEG_2E2 = 3'b001;
    localparam logic [2:0] SEL_REG_2E  = 3'b010;
    localparam logic [2:0] SEL_E2      = 3'b011;
    localparam logic [2:0] SEL_NEG_2E3 = 3'b100;
    localparam logic [2:0] SEL_REG_5E  = 3'b101;
    localparam logic [2:0] SEL_2E3     = 3'b110;
    localparam logic [2:0] SEL_IDLE    = 3'b111;

    // Step i occupies SCHED[3*i +: 3] and CIN[i]; carry-in completes the
    // two's-complement negation on the complement codes.
    localparam logic [3*N_STEPS-1:0] SCHED = {SEL_NEG_2E3, SEL_2E3, SEL_E2, SEL_REG_2E,
                                              SEL_NEG_2E2, SEL_NEG_E2, SEL_REG_5E};
    localparam logic [N_STEPS-1:0]   CIN   = 7'b1000110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/interp_sat.sv
// Clamps the one-bit-wider adder result into the signed output range.
module interp_sat #(
    parameter int OUT_WIDTH = 19
) (
    input  logic signed [OUT_WIDTH:0]   i_sum,
    output logic signed [OUT_WIDTH-1:0] o_sat
);

    localparam logic signed [OUT_WIDTH-1:0] MAX_VAL = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] MIN_VAL = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // NOTE: every branch of a combinational block assigns the output, so no latch is inferred.
    always_comb begin
        if (i_sum[OUT_WIDTH] == i_sum[OUT_WIDTH-1]) begin
            o_sat = i_sum[OUT_WIDTH-1:0];
        end else if (i_sum[OUT_WIDTH]) begin
            o_sat = MIN_VAL;
        end else begin
            o_sat = MAX_VAL;
        end
    end

endmodule

// File: rtl/interp_seq_ctrl.sv
// Operand sequencer: latches one pilot set, precomputes -2*E2 and 5*E1, walks the
// select schedule for the shared adder and emits 7 saturated samples over valid/ready.
module interp_seq_ctrl
    import interp_pkg::*;
#(
    parameter int IN_WIDTH  = 17,
    parameter int OUT_WIDTH = 19
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  E1,
    input  logic signed [IN_WIDTH-1:0]  E2,
    input  logic signed [IN_WIDTH-1:0]  E3,
    output logic [2:0]                  sel,
    output logic                        cin,
    output logic signed [IN_WIDTH-1:0]  E2_q,
    output logic signed [IN_WIDTH-1:0]  E3_q,
    output logic signed [IN_WIDTH:0]    reg_2E,
    output logic signed [OUT_WIDTH-1:0] reg_5E,
    input  logic signed [OUT_WIDTH:0]   add_sum,
    output logic signed [OUT_WIDTH-1:0] est_out,
    output logic [2:0]                  est_idx,
    output logic                        est_valid,
    input  logic                        est_ready
);

    state_t                      r_state;
    state_t                      w_next_state;
    logic [2:0]                  r_step;
    logic                        r_in_ready;
    logic signed [IN_WIDTH-1:0]  r_e1;
    logic signed [IN_WIDTH-1:0]  r_e2;
    logic signed [IN_WIDTH-1:0]  r_e3;
    logic signed [IN_WIDTH:0]    r_2e;
    logic signed [OUT_WIDTH-1:0] r_5e;
    logic signed [OUT_WIDTH-1:0] r_est_out;
    logic [2:0]                  r_est_idx;
    logic                        r_est_valid;

    logic                        w_accept;
    logic                        w_adv;
    logic signed [IN_WIDTH:0]    w_e2_x;
    logic signed [OUT_WIDTH-1:0] w_e1_x;
    logic signed [OUT_WIDTH-1:0] w_sat;

    assign w_accept = in_valid && r_in_ready;
    assign w_adv    = !r_est_valid || est_ready;
    assign w_e2_x   = (IN_WIDTH+1)'(r_e2);
    assign w_e1_x   = (OUT_WIDTH)'(r_e1);

    interp_sat #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat (
        .i_sum (add_sum),
        .o_sat (w_sat)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_LOAD;
            ST_LOAD:  w_next_state = ST_RUN;
            ST_RUN:   if (w_adv && r_step == 3'(N_STEPS-1)) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_adv) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        sel = SEL_IDLE;
        cin = 1'b0;
        if (r_state == ST_RUN) begin
            sel = SCHED[3*int'(r_step) +: 3];
            cin = CIN[r_step];
        end
    end

    // NOTE: the operand copies are reset too, so a mid-operation reset leaves no stale set behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_step      <= '0;
            r_e1        <= '0;
            r_e2        <= '0;
            r_e3        <= '0;
            r_2e        <= '0;
            r_5e        <= '0;
            r_est_out   <= '0;
            r_est_idx   <= '0;
            r_est_valid <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == ST_IDLE);
            if (w_accept) begin
                r_e1 <= E1;
                r_e2 <= E2;
                r_e3 <= E3;
            end
            if (r_state == ST_LOAD) begin
                r_2e   <= -(w_e2_x <<< 1);
                r_5e   <= (w_e1_x <<< 2) + w_e1_x;
                r_step <= '0;
            end
            if (r_state == ST_RUN && w_adv) begin
                r_est_out   <= w_sat;
                r_est_idx   <= r_step;
                r_est_valid <= 1'b1;
                r_step      <= r_step + 3'd1;
            end else if (est_ready) begin
                r_est_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign E2_q      = r_e2;
    assign E3_q      = r_e3;
    assign reg_2E    = r_2e;
    assign reg_5E    = r_5e;
    assign est_out   = r_est_out;
    assign est_idx   = r_est_idx;
    assign est_valid = r_est_valid;

endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Directed bench for interp_seq_ctrl: models the operand-A mux plus adder and
// scoreboards every transferred sample against independently derived values.
module tb_interp_seq_ctrl;

    localparam int IN_WIDTH  = 17;
    localparam int OUT_WIDTH = 19;
    localparam int SAT_MAX   = 262143;
    localparam int SAT_MIN   = -262144;

    typedef struct {
        int idx;
        int val;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [IN_WIDTH-1:0]  E1, E2, E3;
    logic [2:0]                  sel;
    logic                        cin;
    logic signed [IN_WIDTH-1:0]  E2_q, E3_q;
    logic signed [IN_WIDTH:0]    reg_2E;
    logic signed [OUT_WIDTH-1:0] reg_5E;
    logic signed [OUT_WIDTH:0]   add_sum;
    logic signed [OUT_WIDTH-1:0] est_out;
    logic [2:0]                  est_idx;
    logic                        est_valid;
    logic                        est_ready;

    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_xfer = 0;
    int   m_e1, m_e2, m_e3;
    int   m_a;
    exp_t sb[$];

    interp_seq_ctrl #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .E1        (E1),
        .E2        (E2),
        .E3        (E3),
        .sel       (sel),
        .cin       (cin),
        .E2_q      (E2_q),
        .E3_q      (E3_q),
        .reg_2E    (reg_2E),
        .reg_5E    (reg_5E),
        .add_sum   (add_sum),
        .est_out   (est_out),
        .est_idx   (est_idx),
        .est_valid (est_valid),
        .est_ready (est_ready)
    );

    always #5 clk = ~clk;

    // Ideal mux + adder: operand A chosen by sel from the bench's own copy of the set.
    always_comb begin
        m_a = 0;
        case (sel)
            3'b000:  m_a = ~m_e2;
            3'b001:  m_a = ~(2 * m_e2);
            3'b010:  m_a = -2 * m_e2;
            3'b011:  m_a = m_e2;
            3'b100:  m_a = ~(2 * m_e3);
            3'b101:  m_a = 5 * m_e1;
            3'b110:  m_a = 2 * m_e3;
            default: m_a = 0;
        endcase
        add_sum = (OUT_WIDTH+1)'(m_a + int'(cin));
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_sample(input int step, input int e1, input int e2, input int e3);
        int v;
        case (step)
            0:       v = 5 * e1;
            1:       v = -e2;
            2, 3:    v = -2 * e2;
            4:       v = e2;
            5:       v = 2 * e3;
            default: v = -2 * e3;
        endcase
        if (v > SAT_MAX) v = SAT_MAX;
        if (v < SAT_MIN) v = SAT_MIN;
        return v;
    endfunction

    // Transfers are judged half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (rst_n && est_valid && est_ready) begin
            check("sample_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("est_idx", est_idx, e.idx);
                check("est_out", est_out, e.val);
            end
            n_xfer++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_set(input int e1, input int e2, input int e3);
        m_e1 = e1; m_e2 = e2; m_e3 = e3;
        E1 = IN_WIDTH'(e1); E2 = IN_WIDTH'(e2); E3 = IN_WIDTH'(e3);
        for (int i = 0; i < 7; i++) sb.push_back('{i, exp_sample(i, e1, e2, e3)});
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!in_ready && n < 60) begin
            tick();
            n++;
        end
        check(tag, in_ready, 1);
    endtask

    task automatic wait_idx(input int idx, input string tag);
        int n = 0;
        while (!(est_valid && est_idx == 3'(idx)) && n < 30) begin
            tick();
            n++;
        end
        check(tag, int'(est_valid && est_idx == 3'(idx)), 1);
    endtask

    initial begin
        int base;
        int nominal [7] = '{500, 50, 100, 100, -50, 60, -60};
        rst_n = 1'b0; in_valid = 1'b0; est_ready = 1'b1;
        E1 = '0; E2 = '0; E3 = '0;
        m_e1 = 0; m_e2 = 0; m_e3 = 0;

        // Reset held: in_valid toggling must not wake the sequencer.
        for (int i = 0; i < 4; i++) begin
            in_valid = ~in_valid;
            tick();
        end
        in_valid = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_est_valid", est_valid, 0);
        check("rst_sel", sel, 3'b111);
        check("rst_cin", cin, 0);
        rst_n = 1'b1;
        #1 check("rel_in_ready_pre", in_ready, 0);
        tick();
        check("rel_in_ready", in_ready, 1);

        // Nominal set with the exact cycle-by-cycle latency.
        E1 = 17'sd100; E2 = -17'sd50; E3 = 17'sd30;
        m_e1 = 100; m_e2 = -50; m_e3 = 30;
        for (int i = 0; i < 7; i++) sb.push_back('{i, nominal[i]});
        base = n_xfer;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("nom_load_busy", in_ready, 0);
        check("nom_load_valid", est_valid, 0);
        tick();
        check("nom_reg_2E", reg_2E, 100);
        check("nom_reg_5E", reg_5E, 500);
        check("nom_step0_sel", sel, 3'b101);
        check("nom_step0_valid", est_valid, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("nom_valid_run", est_valid, 1);
        end
        tick();
        check("nom_in_ready_back", in_ready, 1);
        check("nom_valid_clear", est_valid, 0);
        check("nom_count", n_xfer - base, 7);

        // Backpressure at idx2 for four cycles.
        base = n_xfer;
        send_set(100, -50, 30);
        wait_idx(2, "bp_reach_idx2");
        est_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_sel_hold", sel, 3'b010);
            check("bp_out_hold", est_out, 100);
            check("bp_idx_hold", est_idx, 2);
        end
        est_ready = 1'b1;
        wait_idle("bp_idle");
        check("bp_count", n_xfer - base, 7);

        // Saturation: 5*65535 overflows the signed 19-bit range.
        base = n_xfer;
        send_set(65535, 0, 0);
        tick();
        tick();
        // 327675 viewed as a 19-bit pattern (0x4FFFB)
        check("sat_reg_5E", reg_5E, -196613);
        wait_idle("sat_idle");
        check("sat_count", n_xfer - base, 7);

        // Reset in the middle of a burst.
        send_set(100, -50, 30);
        wait_idx(3, "mid_reach_idx3");
        rst_n = 1'b0;
        #1;
        check("mid_est_valid", est_valid, 0);
        check("mid_sel", sel, 3'b111);
        check("mid_in_ready", in_ready, 0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_ready_again", in_ready, 1);
        base = n_xfer;
        send_set(-100, 20, -7);
        wait_idle("mid_restart_idle");
        check("mid_restart_count", n_xfer - base, 7);

        // in_valid pulses during RUN are ignored.
        base = n_xfer;
        send_set(1234, -321, 77);
        tick();
        tick();
        E1 = 17'sd1; E2 = 17'sd2; E3 = 17'sd3;
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid;
            tick();
        end
        in_valid = 1'b0;
        check("ign_E2_q", E2_q, -321);
        check("ign_E3_q", E3_q, 77);
        wait_idle("ign_idle");
        repeat (3) tick();
        check("ign_count", n_xfer - base, 7);
        check("ign_no_second", est_valid, 0);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
